load_use_hazard_ctrl: RTL
=========================

// Module: load_use_hazard_ctrl
// PURPOSE
//  Parametrised load-use hazard controller for the 5-stage pipeline; generalises single-cycle load stall detection.
//  Tracks loads that have left EX in an age pipeline, so MEM latency may be >1 cycle.
//  Stalls PC and IF/ID and injects a NOP into ID/EX until the load data is forwardable.
//  Also handles a taken-branch flush request and keeps a saturating stall-cycle counter.
// PARAMETERS
//  REG_ADDR_W    5   register-specifier width
//  LOAD_LATENCY  1   min cycles (>=1) between load in EX and a dependent instr in EX
//  ZERO_REG_SAFE 1   1: specifier 0 never causes a hazard
//  CNT_W         16  stall counter width
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  EX_MemRead   in   1           instr in EX is a load
//  EX_rt        in   REG_ADDR_W  load destination in EX
//  ID_rs        in   REG_ADDR_W  source 1 of instr in ID
//  ID_rt        in   REG_ADDR_W  source 2 of instr in ID
//  ID_uses_rs   in   1           ID instr actually reads rs
//  ID_uses_rt   in   1           ID instr actually reads rt
//  flush_req    in   1           branch taken/redirect resolved this cycle
//  cnt_clear    in   1           synchronous clear of stall_count
//  pc_write     out  1           PC update enable
//  IFID_write   out  1           IF/ID register enable
//  IFID_flush   out  1           zero IF/ID contents
//  nop_control  out  1           force control bits of ID/EX to NOP
//  stall_count  out  CNT_W       stall cycles since reset/clear
// BEHAVIOUR
//  - Age pipe: pend_v/pend_rd[k], k=1..LOAD_LATENCY-1 (none when LOAD_LATENCY=1).
//    Each clk: pend[1] <= {EX_MemRead & ~(ZERO_REG_SAFE & EX_rt==0), EX_rt}; pend[k] <= pend[k-1].
//    The pipe advances every cycle, stalled or not.
//  - match(r) = (r!=0 | !ZERO_REG_SAFE) & ((EX_MemRead & EX_rt==r) | any k: pend_v[k] & pend_rd[k]==r).
//  - hazard = (ID_uses_rs & match(ID_rs)) | (ID_uses_rt & match(ID_rt)); combinational, same cycle.
//  - Outputs are combinational, priority flush > hazard > normal:
//      flush_req: pc_write=1, IFID_write=1, IFID_flush=1, nop_control=1 (no stall counted)
//      hazard:    pc_write=0, IFID_write=0, IFID_flush=0, nop_control=1
//      else:      pc_write=1, IFID_write=1, IFID_flush=0, nop_control=0
//  - Stall length: a dependent instr in ID while its load is in EX stalls exactly LOAD_LATENCY cycles.
//    The stall ends when the load ages past LOAD_LATENCY-1. An injected NOP in EX has EX_MemRead=0,
//    so it never extends the stall.
//  - stall_count: +1 on each clk where hazard & ~flush_req; saturates at 2^CNT_W-1.
//    cnt_clear has priority over increment and loads 0.
//  - Reset (rst_n low, async): all pend_v=0, stall_count=0. Outputs then depend only on EX inputs.
//    Reset mid-stall drops all tracked loads; release resumes with an empty age pipe.
//  - Both sources matching, or several pending matches, give a single stall, not cumulative.
//  - LOAD_LATENCY=1, ZERO_REG_SAFE=0, uses_*=1 and flush_req=0 give classic one-cycle load-use stall behaviour.
// TESTING
//  T1 L=1: EX load rt=5, ID rs=5 -> 1 cycle pc_write=0, nop_control=1; next cycle clear; stall_count=1.
//  T2 L=3: load rt=7 then dependent rt=7 in ID -> stall 3 consecutive cycles; stall_count=3.
//     Same with an independent instr between -> stall 2.
//  T3 ZERO_REG_SAFE=1: load rt=0, ID rs=0 -> no stall. ID_uses_rt=0 with rt match -> no stall.
//  T4 Hazard and flush_req same cycle -> IFID_flush=1, pc_write=1, nop_control=1; count unchanged.
//  T5 CNT_W=2: 5 hazard cycles -> stall_count sticks at 3; cnt_clear with hazard -> 0.
//  T6 L=3: rst_n low 1 cycle mid-stall (async, off-edge) -> pend cleared immediately.
//     After release with EX_MemRead=0 -> no stall, stall_count=0.

Source files
------------

// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard controller: stalls PC/IF-ID and bubbles ID/EX until a load's data is forwardable.
// Hazard/flush outputs are combinational in the same cycle; an age pipe tracks loads that have left EX.
module load_use_hazard_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int LOAD_LATENCY  = 1,
  parameter int ZERO_REG_SAFE = 1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_rt,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_uses_rs,
  input  logic                  ID_uses_rt,
  input  logic                  flush_req,
  input  logic                  cnt_clear,
  output logic                  pc_write,
  output logic                  IFID_write,
  output logic                  IFID_flush,
  output logic                  nop_control,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             zero_safe;
  logic             ex_ld_vld;
  logic             pend_hit_rs;
  logic             pend_hit_rt;
  logic             rs_hit;
  logic             rt_hit;
  logic             hazard;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero_safe = (ZERO_REG_SAFE != 0);
  assign ex_ld_vld = EX_MemRead & ~(zero_safe & (EX_rt == '0));

  generate
    if (LOAD_LATENCY > 1) begin : g_pend
      localparam int PD = LOAD_LATENCY - 1;
      logic [PD:1]           pend_v_q;
      logic [REG_ADDR_W-1:0] pend_rd_q [PD:1];

      // The age pipe shifts every cycle regardless of stall, so a load's age is wall-clock time.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_v_q <= '0;
          for (int k = 1; k <= PD; k++) pend_rd_q[k] <= '0;
        end else begin
          pend_v_q[1]  <= ex_ld_vld;
          pend_rd_q[1] <= EX_rt;
          for (int k = 2; k <= PD; k++) begin
            pend_v_q[k]  <= pend_v_q[k-1];
            pend_rd_q[k] <= pend_rd_q[k-1];
          end
        end
      end

      always_comb begin
        pend_hit_rs = 1'b0;
        pend_hit_rt = 1'b0;
        for (int k = 1; k <= PD; k++) begin
          if (pend_v_q[k] && (pend_rd_q[k] == ID_rs)) pend_hit_rs = 1'b1;
          if (pend_v_q[k] && (pend_rd_q[k] == ID_rt)) pend_hit_rt = 1'b1;
        end
      end
    end else begin : g_no_pend
      assign pend_hit_rs = 1'b0;
      assign pend_hit_rt = 1'b0;
    end
  endgenerate

  assign rs_hit = ((ID_rs != '0) | ~zero_safe) & ((EX_MemRead & (EX_rt == ID_rs)) | pend_hit_rs);
  assign rt_hit = ((ID_rt != '0) | ~zero_safe) & ((EX_MemRead & (EX_rt == ID_rt)) | pend_hit_rt);
  assign hazard = (ID_uses_rs & rs_hit) | (ID_uses_rt & rt_hit);

  always_comb begin
    pc_write    = 1'b1;
    IFID_write  = 1'b1;
    IFID_flush  = 1'b0;
    nop_control = 1'b0;
    if (flush_req) begin
      IFID_flush  = 1'b1;
      nop_control = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      IFID_write  = 1'b0;
      nop_control = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (hazard && !flush_req && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;

endmodule
